// File: rtl/fir_xifu_scoreboard_if.sv
// Issue/commit handshake between the CV32E40X offload port and the FIR XIFU scoreboard.
interface fir_xifu_scoreboard_if #(
  parameter int NUM_ID = 4
);
  localparam int IdW = $clog2(NUM_ID);

  logic           issue_valid;
  logic [IdW-1:0] issue_id;
  logic           issue_accept;
  logic           issue_ready;
  logic           commit_valid;
  logic [IdW-1:0] commit_id;
  logic           commit_kill;

  modport master (
    output issue_valid, issue_id, issue_accept,
    output commit_valid, commit_id, commit_kill,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_id, issue_accept,
    input  commit_valid, commit_id, commit_kill,
    output issue_ready
  );
endinterface

// File: rtl/fir_xifu_scoreboard.sv
// Per-ID scoreboard for offloaded xfir instructions: tracks issue, commit/kill and
// write-back completion, and drives the ctrl2wb status vectors.
module fir_xifu_scoreboard #(
  parameter int NUM_ID = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  fir_xifu_scoreboard_if.slave          xif,
  input  logic [NUM_ID-1:0]             clear_i,
  input  logic                          flush_i,
  output logic [NUM_ID-1:0]             issue_o,
  output logic [NUM_ID-1:0]             commit_o,
  output logic [NUM_ID-1:0]             kill_o,
  output logic [$clog2(NUM_ID+1)-1:0]   outstanding_o,
  output logic                          full_o,
  output logic                          err_o
);

  localparam int IdW  = $clog2(NUM_ID);
  localparam int CntW = $clog2(NUM_ID + 1);

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } entry_state_e;

  entry_state_e state_q [NUM_ID];
  entry_state_e state_d [NUM_ID];

  logic              issue_fire;
  logic [NUM_ID-1:0] issue_hit;
  logic [NUM_ID-1:0] commit_hit;
  logic              err_event;
  logic [CntW-1:0]   free_cnt;
  logic [CntW-1:0]   outstanding_d;

  // Ready looks only at registered state so a same-cycle clear can never re-open an ID.
  assign xif.issue_ready = (state_q[xif.issue_id] == FREE);
  assign issue_fire      = xif.issue_valid & xif.issue_ready & xif.issue_accept;

  always_comb begin
    issue_hit  = '0;
    commit_hit = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      issue_hit[i]  = issue_fire && (xif.issue_id == IdW'(i));
      commit_hit[i] = xif.commit_valid && (xif.commit_id == IdW'(i));
    end
  end

  // Erroneous commits/clears are flagged and otherwise ignored; legal events on
  // other IDs in the same cycle still take effect.
  always_comb begin
    err_event = 1'b0;
    free_cnt  = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        FREE: begin
          if (issue_hit[i]) begin
            if (commit_hit[i]) state_d[i] = xif.commit_kill ? KILLED : COMMITTED;
            else               state_d[i] = ISSUED;
          end else if (commit_hit[i]) begin
            err_event = 1'b1;
          end
          if (clear_i[i]) err_event = 1'b1;
        end
        ISSUED: begin
          if (commit_hit[i]) state_d[i] = xif.commit_kill ? KILLED : COMMITTED;
          if (clear_i[i]) err_event = 1'b1;
        end
        COMMITTED: begin
          if (commit_hit[i]) err_event = 1'b1;
          if (clear_i[i]) begin
            state_d[i] = FREE;
            free_cnt   = free_cnt + CntW'(1);
          end
        end
        KILLED: begin
          if (commit_hit[i]) err_event = 1'b1;
          if (clear_i[i] || flush_i) begin
            state_d[i] = FREE;
            free_cnt   = free_cnt + CntW'(1);
          end
        end
      endcase
    end
    outstanding_d = outstanding_o + CntW'(issue_fire) - free_cnt;
  end

  // Status vectors and counters are registered from next state so they match the
  // entry states exactly in every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ID; i++) state_q[i] <= FREE;
      issue_o       <= '0;
      commit_o      <= '0;
      kill_o        <= '0;
      outstanding_o <= '0;
      full_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        state_q[i]  <= state_d[i];
        issue_o[i]  <= (state_d[i] != FREE);
        commit_o[i] <= (state_d[i] == COMMITTED);
        kill_o[i]   <= (state_d[i] == KILLED);
      end
      outstanding_o <= outstanding_d;
      full_o        <= (outstanding_d == CntW'(NUM_ID));
      err_o         <= err_o | err_event;
    end
  end

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Directed bench for fir_xifu_scoreboard: expected status is queued with each stimulus
// and popped one cycle later when the registered outputs are sampled.
module tb_fir_xifu_scoreboard;

  typedef struct packed {
    logic [3:0] iss;
    logic [3:0] com;
    logic [3:0] kil;
    logic [2:0] outs;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] clear_i = '0;
  logic       flush_i = 1'b0;
  logic [3:0] issue_o, commit_o, kill_o;
  logic [2:0] outstanding_o;
  logic       full_o, err_o;

  int   test_count = 0;
  int   fail_count = 0;
  exp_t exp_q[$];

  fir_xifu_scoreboard_if #(.NUM_ID(4)) xif ();

  fir_xifu_scoreboard #(.NUM_ID(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .xif           (xif),
    .clear_i       (clear_i),
    .flush_i       (flush_i),
    .issue_o       (issue_o),
    .commit_o      (commit_o),
    .kill_o        (kill_o),
    .outstanding_o (outstanding_o),
    .full_o        (full_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    test_count++;
    assert (obs === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(
    input string      tag,
    input logic       iv,
    input logic [1:0] iid,
    input logic       iacc,
    input logic       cv,
    input logic [1:0] cid,
    input logic       ck,
    input logic [3:0] clr,
    input logic       fl,
    input logic       exp_ready,
    input logic [3:0] ei,
    input logic [3:0] ec,
    input logic [3:0] ek,
    input logic [2:0] eo,
    input logic       ee
  );
    exp_t e;
    @(negedge clk_i);
    xif.issue_valid  = iv;
    xif.issue_id     = iid;
    xif.issue_accept = iacc;
    xif.commit_valid = cv;
    xif.commit_id    = cid;
    xif.commit_kill  = ck;
    clear_i          = clr;
    flush_i          = fl;
    e.iss  = ei;
    e.com  = ec;
    e.kil  = ek;
    e.outs = eo;
    e.full = (eo == 3'd4);
    e.err  = ee;
    exp_q.push_back(e);
    #1;
    check({tag, ".ready"}, 32'(xif.issue_ready), 32'(exp_ready));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk_i);
    #1;
    check({tag, ".queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".issue_o"},  32'(issue_o),       32'(e.iss));
      check({tag, ".commit_o"}, 32'(commit_o),      32'(e.com));
      check({tag, ".kill_o"},   32'(kill_o),        32'(e.kil));
      check({tag, ".outst"},    32'(outstanding_o), 32'(e.outs));
      check({tag, ".full_o"},   32'(full_o),        32'(e.full));
      check({tag, ".err_o"},    32'(err_o),         32'(e.err));
    end
  endtask

  task automatic step(
    input string      tag,
    input logic       iv,
    input logic [1:0] iid,
    input logic       iacc,
    input logic       cv,
    input logic [1:0] cid,
    input logic       ck,
    input logic [3:0] clr,
    input logic       fl,
    input logic       exp_ready,
    input logic [3:0] ei,
    input logic [3:0] ec,
    input logic [3:0] ek,
    input logic [2:0] eo,
    input logic       ee
  );
    applyStimulus(tag, iv, iid, iacc, cv, cid, ck, clr, fl, exp_ready, ei, ec, ek, eo, ee);
    checkOutput(tag);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".issue_o"},  32'(issue_o),         32'd0);
    check({tag, ".commit_o"}, 32'(commit_o),        32'd0);
    check({tag, ".kill_o"},   32'(kill_o),          32'd0);
    check({tag, ".outst"},    32'(outstanding_o),   32'd0);
    check({tag, ".full_o"},   32'(full_o),          32'd0);
    check({tag, ".err_o"},    32'(err_o),           32'd0);
    check({tag, ".ready"},    32'(xif.issue_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    xif.issue_valid  = 1'b0;
    xif.issue_id     = 2'd0;
    xif.issue_accept = 1'b0;
    xif.commit_valid = 1'b0;
    xif.commit_id    = 2'd0;
    xif.commit_kill  = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checkResetState("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    //   tag        iv iid acc cv cid kill clr     fl rdy  issue    commit   kill     out  err
    step("iss2",    1, 2, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0000, 3'd1, 0);
    step("reiss2",  1, 2, 1,   0, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 3'd1, 0);
    step("rej0",    1, 0, 0,   0, 0, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0000, 3'd1, 0);
    step("com2",    0, 2, 0,   1, 2, 0, 4'b0000, 0, 0, 4'b0100, 4'b0100, 4'b0000, 3'd1, 0);
    step("clr2",    0, 2, 0,   0, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);

    step("isscom1", 1, 1, 1,   1, 1, 0, 4'b0000, 0, 1, 4'b0010, 4'b0010, 4'b0000, 3'd1, 0);
    step("clr1",    0, 1, 0,   0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
    step("rdy1",    0, 1, 0,   0, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);

    step("fill0",   1, 0, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 3'd1, 0);
    step("fill1",   1, 1, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0011, 4'b0000, 4'b0000, 3'd2, 0);
    step("fill2",   1, 2, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0111, 4'b0000, 4'b0000, 3'd3, 0);
    step("fill3",   1, 3, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b1111, 4'b0000, 4'b0000, 3'd4, 0);
    step("fullrdy", 1, 0, 1,   0, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 4'b0000, 3'd4, 0);
    step("com0",    0, 0, 0,   1, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0001, 4'b0000, 3'd4, 0);
    step("com3",    0, 0, 0,   1, 3, 0, 4'b0000, 0, 0, 4'b1111, 4'b1001, 4'b0000, 3'd4, 0);
    step("clr03",   0, 0, 0,   0, 0, 0, 4'b1001, 0, 0, 4'b0110, 4'b0000, 4'b0000, 3'd2, 0);

    // clear of 1, kill of 2 and issue of 0 land on one edge
    step("com1",    0, 0, 0,   1, 1, 0, 4'b0000, 0, 1, 4'b0110, 4'b0010, 4'b0000, 3'd2, 0);
    step("mixed",   1, 0, 1,   1, 2, 1, 4'b0010, 0, 1, 4'b0101, 4'b0000, 4'b0100, 3'd2, 0);
    step("flclr2",  0, 0, 0,   1, 0, 0, 4'b0100, 1, 0, 4'b0001, 4'b0001, 4'b0000, 3'd1, 0);
    step("clr0",    0, 0, 0,   0, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);

    step("kiss0",   1, 0, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 3'd1, 0);
    step("kill0",   0, 0, 0,   1, 0, 1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0001, 3'd1, 0);
    step("flush",   0, 0, 0,   0, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);

    step("eiss2",   1, 2, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0000, 3'd1, 0);
    step("ecom3",   0, 3, 0,   1, 3, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0000, 3'd1, 1);
    step("eclr2",   0, 2, 0,   0, 0, 0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 4'b0000, 3'd1, 1);
    step("sticky",  0, 2, 0,   0, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 3'd1, 1);

    step("pre0",    1, 0, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0101, 4'b0000, 4'b0000, 3'd2, 1);
    step("pre1",    1, 1, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0111, 4'b0000, 4'b0000, 3'd3, 1);

    @(negedge clk_i);
    xif.issue_valid  = 1'b0;
    xif.issue_id     = 2'd2;
    xif.issue_accept = 1'b0;
    xif.commit_valid = 1'b0;
    clear_i          = '0;
    flush_i          = 1'b0;
    rst_i            = 1'b1;
    #1;
    checkResetState("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;

    step("postrst", 1, 2, 1,   0, 0, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0000, 3'd1, 0);

    check("queue.empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
